// File: rtl/lsi_wb_pkg.sv
// Shared constants for the two-master Wishbone arbiter: FSM encoding, bus widths
// and the bundled per-master request type.
package lsi_wb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam int ADR_W      = 16;
  localparam int DAT_W      = 16;
  localparam int SEL_W      = 2;
  localparam int TOUT_W_DEF = 6;

  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/lsi_wb_tout.sv
// Bus-timeout counter: counts consecutive unacknowledged strobe cycles and
// flags expiry once the count has saturated while the strobe is still pending.
module lsi_wb_tout
  import lsi_wb_pkg::*;
#(
  parameter int TOUT_W = TOUT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  logic [TOUT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run) begin
      r_cnt <= '0;
    end else if (!(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = run & (&r_cnt);

endmodule

// File: rtl/lsi_wb_arb.sv
// Two-master (CPU m0, DMA m1) Wishbone arbiter onto a single slave bus.
// Optional bus timeout with sticky error flag: define LSI_WB_ARB_TIMEOUT_EN.
module lsi_wb_arb
  import lsi_wb_pkg::*;
#(
  parameter int TOUT_W = TOUT_W_DEF
) (
  input  logic             vm_clk_p,
  input  logic             vm_rst_n,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic             m0_gnt_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             m1_gnt_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic [SEL_W-1:0] s_sel_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  input  logic             berr_clr_i,
  output logic             berr_o
);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_last1;
  logic       w_last1_next;
  logic       w_own0;
  logic       w_own1;
  logic       w_expired;
  wb_req_t    w_m0;
  wb_req_t    w_m1;
  wb_req_t    w_s;

  assign w_m0   = {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i};
  assign w_m1   = {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i};
  assign w_own0 = (r_state == ST_OWN0);
  assign w_own1 = (r_state == ST_OWN1);

  always_comb begin
    w_s = '0;
    case (r_state)
      ST_OWN0: w_s = w_m0;
      ST_OWN1: w_s = w_m1;
      default: w_s = '0;
    endcase
    w_s.stb = w_s.stb & w_s.cyc;
  end

  assign s_cyc_o = w_s.cyc;
  assign s_stb_o = w_s.stb;
  assign s_we_o  = w_s.we;
  assign s_adr_o = w_s.adr;
  assign s_dat_o = w_s.dat;
  assign s_sel_o = w_s.sel;

  assign m0_gnt_o = w_own0;
  assign m1_gnt_o = w_own1;
  assign m0_ack_o = s_ack_i & w_own0;
  assign m1_ack_o = s_ack_i & w_own1;
  assign m0_dat_o = w_own0 ? s_dat_i : '0;
  assign m1_dat_o = w_own1 ? s_dat_i : '0;

  // r_last1 remembers who was granted last; ties go to the other master.
  always_comb begin
    w_state_next = r_state;
    w_last1_next = r_last1;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_state_next = r_last1 ? ST_OWN0 : ST_OWN1;
          w_last1_next = ~r_last1;
        end else if (m1_cyc_i) begin
          w_state_next = ST_OWN1;
          w_last1_next = 1'b1;
        end else if (m0_cyc_i) begin
          w_state_next = ST_OWN0;
          w_last1_next = 1'b0;
        end
      end
      ST_OWN0: if (!m0_cyc_i || w_expired) w_state_next = ST_IDLE;
      ST_OWN1: if (!m1_cyc_i || w_expired) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
    if (!vm_rst_n) begin
      r_state <= ST_IDLE;
      r_last1 <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_last1 <= w_last1_next;
    end
  end

`ifdef LSI_WB_ARB_TIMEOUT_EN
  logic w_run;
  logic r_berr;

  assign w_run = w_s.stb & ~s_ack_i;

  lsi_wb_tout #(
    .TOUT_W (TOUT_W)
  ) u_tout (
    .clk     (vm_clk_p),
    .rst_n   (vm_rst_n),
    .run     (w_run),
    .expired (w_expired)
  );

  // A timeout in the same cycle as a clear request leaves the flag set.
  always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
    if (!vm_rst_n) begin
      r_berr <= 1'b0;
    end else if (w_expired) begin
      r_berr <= 1'b1;
    end else if (berr_clr_i) begin
      r_berr <= 1'b0;
    end
  end

  assign m0_err_o = w_expired & w_own0;
  assign m1_err_o = w_expired & w_own1;
  assign berr_o   = r_berr;
`else
  logic [TOUT_W:0] w_unused;

  assign w_unused  = {{TOUT_W{1'b0}}, berr_clr_i};
  assign w_expired = 1'b0;
  assign m0_err_o  = 1'b0;
  assign m1_err_o  = 1'b0;
  assign berr_o    = 1'b0;
`endif

endmodule
